debounce_bank: RTL



---
 rtl/debounce_bank.sv | 111 +++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// debounce_bank: per-channel synchroniser and debouncer for asynchronous board
// inputs. Each channel has a sync chain, a stable-window counter, a debounced
// level and registered single-cycle rise/fall pulses. any_event is the
// registered OR of every channel's pulses.
module debounce_bank #(
  parameter int                NUM_CH          = 4,
  parameter int                SYNC_DELAY_LEN  = 2,
  parameter int                DEBOUNCE_CYCLES = 650000,
  parameter logic [NUM_CH-1:0] RESET_VAL       = {NUM_CH{1'b0}}
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] in,
  output logic [NUM_CH-1:0] clean,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic              any_event
);

  // The counter only needs to reach D-1, where it saturates.
  localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CH-1:0] rise_next;
  logic [NUM_CH-1:0] fall_next;
  logic              any_event_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [SYNC_DELAY_LEN-1:0] sync_reg;
      logic                      synced;
      logic                      prev_reg;
      logic                      prev_next;
      logic                      clean_reg;
      logic                      clean_next;
      logic                      rise_reg;
      logic                      fall_reg;
      logic                      ch_rise_next;
      logic                      ch_fall_next;
      logic [CNT_W-1:0]          cnt_reg;
      logic [CNT_W-1:0]          cnt_next;

      assign synced = sync_reg[SYNC_DELAY_LEN-1];

      // Shift the raw pad value through the synchroniser chain.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync_reg <= {SYNC_DELAY_LEN{RESET_VAL[gi]}};
        end else begin
          sync_reg <= {sync_reg[SYNC_DELAY_LEN-2:0], in[gi]};
        end
      end

      // Restart the window on any change, otherwise count up to D-1 and then
      // commit prev to clean; a pulse only fires when clean actually moves.
      always_comb begin
        prev_next    = prev_reg;
        cnt_next     = cnt_reg;
        clean_next   = clean_reg;
        ch_rise_next = 1'b0;
        ch_fall_next = 1'b0;
        if (synced != prev_reg) begin
          prev_next = synced;
          cnt_next  = '0;
        end else if (cnt_reg == CNT_MAX) begin
          clean_next   = prev_reg;
          ch_rise_next = prev_reg & ~clean_reg;
          ch_fall_next = ~prev_reg & clean_reg;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end

      // Hold the debounce state and the registered event pulses.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          prev_reg  <= RESET_VAL[gi];
          clean_reg <= RESET_VAL[gi];
          cnt_reg   <= '0;
          rise_reg  <= 1'b0;
          fall_reg  <= 1'b0;
        end else begin
          prev_reg  <= prev_next;
          clean_reg <= clean_next;
          cnt_reg   <= cnt_next;
          rise_reg  <= ch_rise_next;
          fall_reg  <= ch_fall_next;
        end
      end

      assign rise_next[gi] = ch_rise_next;
      assign fall_next[gi] = ch_fall_next;
      assign clean[gi]     = clean_reg;
      assign rise[gi]      = rise_reg;
      assign fall[gi]      = fall_reg;
    end
  endgenerate

  // Register the OR of next-cycle pulses so any_event lines up with rise/fall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      any_event_reg <= 1'b0;
    end else begin
      any_event_reg <= |(rise_next | fall_next);
    end
  end

  assign any_event = any_event_reg;

endmodule
